evento_boton: RTL and testbench

//  Consumes the clean level produced by a button debouncer and turns it into

---
 rtl/evento_boton.sv | 130 +++++++++++++
 tb/tb_evento_boton.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/evento_boton.sv
// evento_boton
//   Turns a debounced, clock-synchronous button level into single-cycle
//   events: PRESS on press, REPEAT at a fixed cadence while held (after an
//   initial hold delay), RELEASE on release. HELD and LONG are levels that
//   track the pressed / auto-repeat states. One instance per button.
// Ports
//   clk_i      system clock, all logic on posedge
//   rst_ni     synchronous reset, active-low
//   btn_i      debounced button level, 1 = pressed
//   press_o    1-cycle pulse on press
//   repeat_o   1-cycle pulse per auto-repeat interval while held
//   release_o  1-cycle pulse on release
//   held_o     level, 1 in PRESSED or AUTOREP
//   long_o     level, 1 in AUTOREP
module evento_boton #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 25,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o,
  output logic repeat_o,
  output logic release_o,
  output logic held_o,
  output logic long_o
);

  localparam logic [1:0] S_LOCKOUT = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;
  localparam logic [1:0] S_AUTOREP = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rep_q, rep_d;
  logic             rel_q, rel_d;
  logic             held_q, held_d;
  logic             long_q, long_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rep_d   = 1'b0;
    rel_d   = 1'b0;
    held_d  = held_q;
    long_d  = long_q;
    case (state_q)
      // After reset, wait for the button to be seen released so a press
      // held through reset never reports PRESS or RELEASE.
      S_LOCKOUT: if (!btn_i) state_d = S_IDLE;
      S_IDLE: begin
        if (btn_i) begin
          state_d = S_PRESSED;
          cnt_d   = CNT_ONE;
          press_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!btn_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          held_d  = 1'b0;
        end else if (REPEAT_EN && cnt_q == HOLD_M1) begin
          state_d = S_AUTOREP;
          cnt_d   = '0;
          rep_d   = 1'b1;
          long_d  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          // Saturate so a long hold with repeat disabled cannot wrap.
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_AUTOREP: begin
        // Release is tested first: it wins over a repeat due at the same edge.
        if (!btn_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          held_d  = 1'b0;
          long_d  = 1'b0;
        end else if (cnt_q == REP_M1) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_LOCKOUT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_LOCKOUT;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rep_q   <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rep_q   <= rep_d;
      rel_q   <= rel_d;
      held_q  <= held_d;
      long_q  <= long_d;
    end
  end

  assign press_o   = press_q;
  assign repeat_o  = rep_q;
  assign release_o = rel_q;
  assign held_o    = held_q;
  assign long_o    = long_q;

endmodule

// File: tb/tb_evento_boton.sv
// Directed bench for evento_boton (HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4).
// dut0 has auto-repeat enabled, dut1 has it disabled; both see the same
// button and reset. Per-edge outputs are logged into 64-bit masks (bit e =
// value right after edge e) and compared against hand-computed masks.
module tb_evento_boton;
  logic clk = 1'b0;
  logic rst_n, btn;
  logic press0, rep0, rel0, held0, long0;
  logic press1, rep1, rel1, held1, long1;

  always #5 clk = ~clk;

  evento_boton #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4), .REPEAT_EN(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .press_o(press0), .repeat_o(rep0),
    .release_o(rel0), .held_o(held0), .long_o(long0));

  evento_boton #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4), .REPEAT_EN(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .press_o(press1), .repeat_o(rep1),
    .release_o(rel1), .held_o(held1), .long_o(long1));

  int checks = 0;
  int errors = 0;
  logic [63:0] p0, r0, rl0, h0, l0, p1, r1, rl1, h1, l1;
  logic ovl = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit1(input int i);
    logic [63:0] m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic clr();
    {p0, r0, rl0, h0, l0} = '0;
    {p1, r1, rl1, h1, l1} = '0;
  endtask

  task automatic do_reset(input logic b);
    rst_n = 1'b0;
    btn   = b;
    repeat (2) @(posedge clk);
    #1;
    clr();
  endtask

  // Edge e samples btn=bp[e] and rst_n=~rp[e]; outputs logged after the edge.
  task automatic run(input int lo, input int hi, input logic [63:0] bp, input logic [63:0] rp);
    for (int e = lo; e <= hi; e++) begin
      btn   = bp[e];
      rst_n = ~rp[e];
      @(posedge clk);
      #1;
      p0[e] = press0; r0[e] = rep0; rl0[e] = rel0; h0[e] = held0; l0[e] = long0;
      p1[e] = press1; r1[e] = rep1; rl1[e] = rel1; h1[e] = held1; l1[e] = long1;
      if (int'(press0) + int'(rep0) + int'(rel0) > 1) ovl = 1'b1;
      if (int'(press1) + int'(rep1) + int'(rel1) > 1) ovl = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;

    // Reset state
    do_reset(1'b0);
    chk("rst_outs", 64'({press0, rep0, rel0, held0, long0, press1, rep1, rel1, held1, long1}), 64'd0);
    chk("rst_state", 64'(dut0.state_q), 64'd0);

    // 1: short press, edges 10..12 held
    do_reset(1'b0);
    run(1, 20, rng(10, 12), 64'd0);
    chk("t1_press", p0, bit1(10));
    chk("t1_held", h0, rng(10, 12));
    chk("t1_release", rl0, bit1(13));
    chk("t1_repeat", r0, 64'd0);

    // 2: hold edges 10..29; repeats due at 17, 21, 25 and 29
    do_reset(1'b0);
    run(1, 35, rng(10, 29), 64'd0);
    chk("t2_press", p0, bit1(10));
    chk("t2_repeat", r0, bit1(17) | bit1(21) | bit1(25) | bit1(29));
    chk("t2_long", l0, rng(17, 29));
    chk("t2_held", h0, rng(10, 29));
    chk("t2_release", rl0, bit1(30));

    // 3: release sampled at edge 21 while a repeat is due
    do_reset(1'b0);
    run(1, 26, rng(10, 20), 64'd0);
    chk("t3_repeat", r0, bit1(17));
    chk("t3_release", rl0, bit1(21));
    chk("t3_long", l0, rng(17, 20));

    // 4: held through reset, released at 6, re-pressed 10..14
    do_reset(1'b1);
    run(1, 20, rng(1, 5) | rng(10, 14), 64'd0);
    chk("t4_press", p0, bit1(10));
    chk("t4_release", rl0, bit1(15));
    chk("t4_held", h0, rng(10, 14));

    // 5: reset at edge 12 while in AUTOREP (entered at edge 10)
    do_reset(1'b0);
    run(1, 12, rng(3, 20) | rng(24, 25), bit1(12));
    chk("t5_state", 64'(dut0.state_q), 64'd0);
    chk("t5_cnt", 64'(dut0.cnt_q), 64'd0);
    run(13, 30, rng(3, 20) | rng(24, 25), 64'd0);
    chk("t5_press", p0, bit1(3) | bit1(24));
    chk("t5_repeat", r0, bit1(10));
    chk("t5_long", l0, rng(10, 11));
    chk("t5_held", h0, rng(3, 11) | rng(24, 25));
    chk("t5_release", rl0, bit1(26));

    // 6: repeat disabled (dut1), hold edges 5..44
    do_reset(1'b0);
    run(1, 44, rng(5, 44), 64'd0);
    chk("t6_cnt_sat", 64'(dut1.cnt_q), 64'd15);
    run(45, 50, rng(5, 44), 64'd0);
    chk("t6_press", p1, bit1(5));
    chk("t6_repeat", r1, 64'd0);
    chk("t6_long", l1, 64'd0);
    chk("t6_held", h1, rng(5, 44));
    chk("t6_release", rl1, bit1(45));
    chk("t6_cnt_clr", 64'(dut1.cnt_q), 64'd0);

    chk("no_overlap", 64'(ovl), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
